flofifo_mc: RTL and testbench

Multi-channel RX FIFO for flocra. It is the parametrised successor to the single-stream RX FIFO and sits between up to 8 RX decimator channels and the bus readout logic. Each channel's samples are captured into a per-channel holding register, merged by a round-robin arbiter, tagged with their channel number, and stored in one shared memory. The output is first-word-fall-through with a valid/read handshake, exact occupancy, sticky overflow/underflow flags and synchronous reset.

---
 rtl/flofifo_mc.sv | 202 ++++++++++++++++++++
 tb/tb_flofifo_mc.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flofifo_mc.sv
// Multi-channel RX FIFO: per-channel holding registers, round-robin merge into one
// shared memory of {channel, sample} words, first-word-fall-through output.
module flofifo_mc #(
    parameter int LENGTH   = 16384,
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2,
    localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW      = $clog2(LENGTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic [CHANNELS-1:0]       valid_i,
    input  logic                      read_i,
    output logic [CH_BITS+WIDTH-1:0]  data_o,
    output logic                      valid_o,
    output logic [AW:0]               locs_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [CHANNELS-1:0]       err_overflow_o,
    output logic                      err_underflow_o,
    input  logic                      clear_err_i
);

    localparam int DW = CH_BITS + WIDTH;
    localparam logic [AW:0] LEN_W = (AW+1)'(LENGTH);
    localparam logic [AW:0] PF_SLOTS = (AW+1)'(3);

    logic [CHANNELS-1:0] hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0]    hold_data_q [CHANNELS];
    logic [WIDTH-1:0]    hold_data_d [CHANNELS];
    logic [CH_BITS-1:0]  last_q, last_d;

    logic                any_hi, any_lo;
    logic [CH_BITS-1:0]  idx_hi, idx_lo;
    logic                grant_any;
    logic [CH_BITS-1:0]  grant_idx;
    logic [CHANNELS-1:0] grant_vec;
    logic [DW-1:0]       wr_data;
    logic [CHANNELS-1:0] ovf_evt;

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;

    logic                rd_valid_q, rd_valid_d;
    logic [DW-1:0]       rd_data_q;
    logic [DW-1:0]       buf_q [3];
    logic [DW-1:0]       buf_d [3];
    logic [1:0]          n_q, n_d;
    logic [1:0]          n_pop;
    logic                valid_q, valid_d;
    logic                pop;
    logic                issue;
    logic [AW:0]         in_flight;

    logic [CHANNELS-1:0] err_ovf_q, err_ovf_d;
    logic                err_udf_q, err_udf_d;

    logic [DW-1:0]       mem [LENGTH];

    // Round-robin: lowest occupied channel above the last grant, else lowest occupied overall.
    always_comb begin
        any_hi = 1'b0;
        any_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (hold_valid_q[c]) begin
                any_lo = 1'b1;
                idx_lo = CH_BITS'(c);
            end
            if (hold_valid_q[c] && (c > int'(last_q))) begin
                any_hi = 1'b1;
                idx_hi = CH_BITS'(c);
            end
        end
        grant_any = any_lo && (count_q < LEN_W);
        grant_idx = any_hi ? idx_hi : idx_lo;
        last_d    = grant_any ? grant_idx : last_q;
        for (int c = 0; c < CHANNELS; c++) begin
            grant_vec[c] = grant_any && (grant_idx == CH_BITS'(c));
        end
    end

    // A granted holding register can accept a new sample on the same edge it drains.
    always_comb begin
        wr_data = '0;
        ovf_evt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hold_valid_d[c] = hold_valid_q[c] & ~grant_vec[c];
            hold_data_d[c]  = hold_data_q[c];
            if (grant_vec[c]) begin
                wr_data = {CH_BITS'(c), hold_data_q[c]};
            end
            if (valid_i[c]) begin
                if (!hold_valid_q[c] || grant_vec[c]) begin
                    hold_valid_d[c] = 1'b1;
                    hold_data_d[c]  = data_i[c*WIDTH +: WIDTH];
                end else begin
                    ovf_evt[c] = 1'b1;
                end
            end
        end
    end

    // Reads are issued on credit: words in the read stage plus the prefetch queue never exceed three.
    always_comb begin
        pop        = read_i && valid_q;
        in_flight  = (AW+1)'(n_q) + (AW+1)'(rd_valid_q);
        issue      = (count_q > in_flight) && ((in_flight - (AW+1)'(pop)) < PF_SLOTS);
        rd_valid_d = issue;
        rd_ptr_d   = rd_ptr_q + AW'(issue);
        wr_ptr_d   = wr_ptr_q + AW'(grant_any);
        count_d    = count_q + (AW+1)'(grant_any) - (AW+1)'(pop);
        empty_d    = (count_d == '0);
        full_d     = (count_d == LEN_W);

        n_pop = n_q - 2'(pop);
        buf_d = buf_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end
        if (rd_valid_q) begin
            case (n_pop)
                2'd0:    buf_d[0] = rd_data_q;
                2'd1:    buf_d[1] = rd_data_q;
                default: buf_d[2] = rd_data_q;
            endcase
        end
        n_d     = n_pop + 2'(rd_valid_q);
        valid_d = (n_d != 2'd0);

        err_ovf_d = clear_err_i ? ovf_evt : (err_ovf_q | ovf_evt);
        err_udf_d = clear_err_i ? (read_i && !valid_q)
                                : (err_udf_q | (read_i && !valid_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                hold_data_q[c] <= '0;
            end
            last_q     <= CH_BITS'(CHANNELS - 1);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            n_q        <= '0;
            valid_q    <= 1'b0;
            err_ovf_q  <= '0;
            err_udf_q  <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            for (int c = 0; c < CHANNELS; c++) begin
                hold_data_q[c] <= hold_data_d[c];
            end
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= buf_d[i];
            end
            n_q        <= n_d;
            valid_q    <= valid_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
        end
    end

    // Shared storage has no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (issue) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign data_o          = buf_q[0];
    assign valid_o         = valid_q;
    assign locs_o          = count_q;
    assign empty_o         = empty_q;
    assign full_o          = full_q;
    assign err_overflow_o  = err_ovf_q;
    assign err_underflow_o = err_udf_q;

endmodule

// File: tb/tb_flofifo_mc.sv
// Bench for flofifo_mc: directed scenarios plus randomized traffic against a
// queue-based model of the FIFO's observable behaviour.
module tb_flofifo_mc;

    localparam int LENGTH   = 16;
    localparam int WIDTH    = 24;
    localparam int CHANNELS = 2;
    localparam int DW       = 1 + WIDTH;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] data_i;
    logic [CHANNELS-1:0]       valid_i;
    logic                      read_i;
    logic                      clear_err_i;
    logic [DW-1:0]             data_o;
    logic                      valid_o;
    logic [4:0]                locs_o;
    logic                      empty_o;
    logic                      full_o;
    logic [CHANNELS-1:0]       err_overflow_o;
    logic                      err_underflow_o;

    typedef struct {
        logic [DW-1:0] word;
        int            w;
    } entry_t;

    entry_t              mq[$];
    logic                m_hold_v [CHANNELS];
    logic [WIDTH-1:0]    m_hold_d [CHANNELS];
    int                  m_last;
    int                  m_count;
    int                  edge_n = 0;
    logic [CHANNELS-1:0] m_ovf;
    logic                m_udf;

    int n_checks = 0;
    int n_pass   = 0;

    flofifo_mc #(.LENGTH(LENGTH), .WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .read_i         (read_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .locs_o         (locs_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .err_overflow_o (err_overflow_o),
        .err_underflow_o(err_underflow_o),
        .clear_err_i    (clear_err_i)
    );

    always #5 clk = ~clk;

    // A stored word reaches the head two edges after it is written, and never before its predecessor is popped.
    function automatic logic m_valid();
        return (mq.size() > 0) && (mq[0].w + 2 <= edge_n);
    endfunction

    task automatic tick();
        int                  e;
        int                  g;
        logic                pre_v;
        logic                pop;
        logic                udf_e;
        logic [CHANNELS-1:0] ovf_e;
        entry_t              ent;
        e = edge_n + 1;
        if (rst) begin
            mq.delete();
            m_count = 0;
            m_ovf   = '0;
            m_udf   = 1'b0;
            m_last  = CHANNELS - 1;
            for (int c = 0; c < CHANNELS; c++) m_hold_v[c] = 1'b0;
        end else begin
            pre_v = m_valid();
            pop   = read_i && pre_v;
            udf_e = read_i && !pre_v;
            g = -1;
            if (m_count < LENGTH) begin
                for (int i = 1; i <= CHANNELS; i++) begin
                    if (g < 0 && m_hold_v[(m_last + i) % CHANNELS]) g = (m_last + i) % CHANNELS;
                end
            end
            if (pop) void'(mq.pop_front());
            if (g >= 0) begin
                ent.word = {1'(g), m_hold_d[g]};
                ent.w    = e;
                mq.push_back(ent);
                m_hold_v[g] = 1'b0;
                m_last      = g;
            end
            m_count = m_count + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
            ovf_e = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (valid_i[c]) begin
                    if (!m_hold_v[c]) begin
                        m_hold_v[c] = 1'b1;
                        m_hold_d[c] = data_i[c*WIDTH +: WIDTH];
                    end else begin
                        ovf_e[c] = 1'b1;
                    end
                end
            end
            m_ovf = clear_err_i ? ovf_e : (m_ovf | ovf_e);
            m_udf = clear_err_i ? udf_e : (m_udf | udf_e);
        end
        @(posedge clk);
        #1;
        edge_n = e;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid_i     = 2'($urandom());
            data_i      = {24'($urandom()), 24'($urandom())};
            read_i      = 1'($urandom());
            clear_err_i = 1'($urandom());
            tick();
        end
        rst = 1'b0; valid_i = '0; read_i = 1'b0; clear_err_i = 1'b0;
        n_checks++; if (data_o !== '0) $display("[TB] FAIL reset_data: got %h want 0", data_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (locs_o !== 5'd0) $display("[TB] FAIL reset_locs: got %0d want 0", locs_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL reset_empty: got %b want 1", empty_o); else n_pass++;
        n_checks++; if (full_o !== 1'b0) $display("[TB] FAIL reset_full: got %b want 0", full_o); else n_pass++;
        n_checks++; if (err_overflow_o !== 2'b00) $display("[TB] FAIL reset_ovf: got %b want 00", err_overflow_o); else n_pass++;
        n_checks++; if (err_underflow_o !== 1'b0) $display("[TB] FAIL reset_udf: got %b want 0", err_underflow_o); else n_pass++;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 5; i++) begin
            valid_i = 2'b01;
            data_i  = {24'h0, 24'(i)};
            tick();
            if (i == 3) begin
                n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL stream_early_valid: got %b want 0", valid_o); else n_pass++;
            end
            if (i == 4) begin
                n_checks++;
                if (valid_o !== 1'b1 || data_o !== {1'b0, 24'h000001})
                    $display("[TB] FAIL stream_first_word: got valid=%b data=%h want valid=1 data=%h", valid_o, data_o, {1'b0, 24'h000001});
                else n_pass++;
            end
        end
        valid_i = '0;
        read_i  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            n_checks++;
            if (valid_o !== 1'b1 || data_o !== {1'b0, 24'(i)})
                $display("[TB] FAIL stream_pop_%0d: got valid=%b data=%h want valid=1 data=%h", i, valid_o, data_o, {1'b0, 24'(i)});
            else n_pass++;
            tick();
        end
        read_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL stream_end_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (locs_o !== 5'd0) $display("[TB] FAIL stream_end_locs: got %0d want 0", locs_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL stream_end_empty: got %b want 1", empty_o); else n_pass++;
    endtask

    task automatic test_round_robin();
        int            k;
        logic [DW-1:0] seen[$];
        logic          dup;
        rst = 1'b1; tick(); rst = 1'b0;
        valid_i = 2'b11;
        data_i  = {24'h00000B, 24'h00000A};
        tick();
        valid_i = '0;
        k = 0;
        while (!valid_o && k < 10) begin
            tick();
            k++;
        end
        n_checks++; if (k !== 3) $display("[TB] FAIL rr_latency: got %0d edges want 3", k); else n_pass++;
        n_checks++; if (data_o !== {1'b0, 24'h00000A}) $display("[TB] FAIL rr_first: got %h want %h", data_o, {1'b0, 24'h00000A}); else n_pass++;
        read_i = 1'b1;
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== {1'b1, 24'h00000B})
            $display("[TB] FAIL rr_second: got valid=%b data=%h want valid=1 data=%h", valid_o, data_o, {1'b1, 24'h00000B});
        else n_pass++;
        tick();
        read_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL rr_drained: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (err_overflow_o !== 2'b00) $display("[TB] FAIL rr_no_ovf: got %b want 00", err_overflow_o); else n_pass++;

        for (int i = 0; i < 4; i++) begin
            valid_i = 2'b11;
            data_i  = {24'(32'h200 + 2*i + 1), 24'(32'h200 + 2*i)};
            tick();
        end
        valid_i = '0;
        n_checks++; if (err_overflow_o !== 2'b11) $display("[TB] FAIL rr_ovf: got %b want 11", err_overflow_o); else n_pass++;
        for (int cyc = 0; cyc < 20; cyc++) begin
            read_i = m_valid();
            n_checks++; if (valid_o !== m_valid()) $display("[TB] FAIL rr_drain_valid: got %b want %b", valid_o, m_valid()); else n_pass++;
            if (m_valid()) begin
                n_checks++; if (data_o !== mq[0].word) $display("[TB] FAIL rr_drain_data: got %h want %h", data_o, mq[0].word); else n_pass++;
                dup = 1'b0;
                foreach (seen[j]) if (seen[j] === data_o) dup = 1'b1;
                n_checks++; if (dup) $display("[TB] FAIL rr_unique: got repeated word %h want fresh word", data_o); else n_pass++;
                seen.push_back(data_o);
            end
            tick();
        end
        read_i = 1'b0;
        n_checks++; if (seen.size() != 5) $display("[TB] FAIL rr_word_count: got %0d want 5", seen.size()); else n_pass++;
    endtask

    task automatic test_full_wrap();
        int exp_v;
        clear_err_i = 1'b1; tick(); clear_err_i = 1'b0;
        n_checks++; if (err_overflow_o !== 2'b00) $display("[TB] FAIL full_clear_ovf: got %b want 00", err_overflow_o); else n_pass++;
        for (int i = 1; i <= 16; i++) begin
            valid_i = 2'b01;
            data_i  = {24'h0, 24'(32'h100 + i)};
            tick();
        end
        valid_i = '0;
        tick();
        n_checks++; if (full_o !== 1'b1) $display("[TB] FAIL full_flag: got %b want 1", full_o); else n_pass++;
        n_checks++; if (locs_o !== 5'd16) $display("[TB] FAIL full_locs: got %0d want 16", locs_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b0) $display("[TB] FAIL full_empty: got %b want 0", empty_o); else n_pass++;
        valid_i = 2'b01; data_i = {24'h0, 24'h000111}; tick();
        n_checks++; if (locs_o !== 5'd16) $display("[TB] FAIL full_hold_locs: got %0d want 16", locs_o); else n_pass++;
        data_i = {24'h0, 24'h000112}; tick();
        valid_i = '0;
        n_checks++; if (err_overflow_o !== 2'b01) $display("[TB] FAIL full_ovf: got %b want 01", err_overflow_o); else n_pass++;
        read_i = 1'b1; tick(); read_i = 1'b0;
        n_checks++; if (locs_o !== 5'd15) $display("[TB] FAIL full_pop_locs: got %0d want 15", locs_o); else n_pass++;
        tick();
        n_checks++; if (locs_o !== 5'd16) $display("[TB] FAIL full_refill_locs: got %0d want 16", locs_o); else n_pass++;
        exp_v = 32'h102;
        for (int cyc = 0; cyc < 30; cyc++) begin
            read_i = m_valid();
            if (m_valid()) begin
                n_checks++;
                if (valid_o !== 1'b1 || data_o !== {1'b0, 24'(exp_v)})
                    $display("[TB] FAIL wrap_order: got valid=%b data=%h want valid=1 data=%h", valid_o, data_o, {1'b0, 24'(exp_v)});
                else n_pass++;
                exp_v++;
            end
            tick();
        end
        read_i = 1'b0;
        n_checks++; if (exp_v != 32'h112) $display("[TB] FAIL wrap_count: got %h want 112", exp_v); else n_pass++;
        n_checks++; if (empty_o !== 1'b1 || locs_o !== 5'd0) $display("[TB] FAIL wrap_empty: got empty=%b locs=%0d want 1/0", empty_o, locs_o); else n_pass++;
    endtask

    task automatic test_underflow();
        clear_err_i = 1'b1; tick(); clear_err_i = 1'b0;
        read_i = 1'b1; tick(); read_i = 1'b0;
        n_checks++; if (err_underflow_o !== 1'b1) $display("[TB] FAIL udf_set: got %b want 1", err_underflow_o); else n_pass++;
        n_checks++; if (locs_o !== 5'd0) $display("[TB] FAIL udf_locs: got %0d want 0", locs_o); else n_pass++;
        clear_err_i = 1'b1; tick();
        n_checks++; if (err_underflow_o !== 1'b0) $display("[TB] FAIL udf_clear: got %b want 0", err_underflow_o); else n_pass++;
        read_i = 1'b1; tick();
        read_i = 1'b0; clear_err_i = 1'b0;
        n_checks++; if (err_underflow_o !== 1'b1) $display("[TB] FAIL udf_clear_coincident: got %b want 1", err_underflow_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL udf_valid: got %b want 0", valid_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 6; i++) begin
            valid_i = 2'b10;
            data_i  = {24'(32'h300 + i), 24'h0};
            tick();
        end
        valid_i = '0;
        read_i = 1'b1; rst = 1'b1;
        tick();
        read_i = 1'b0; rst = 1'b0;
        n_checks++; if (locs_o !== 5'd0) $display("[TB] FAIL mid_locs: got %0d want 0", locs_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("[TB] FAIL mid_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL mid_empty: got %b want 1", empty_o); else n_pass++;
        valid_i = 2'b11; data_i = {24'h000022, 24'h000021}; tick(); valid_i = '0;
        tick(); tick(); tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== {1'b0, 24'h000021})
            $display("[TB] FAIL mid_after_first: got valid=%b data=%h want valid=1 data=%h", valid_o, data_o, {1'b0, 24'h000021});
        else n_pass++;
        read_i = 1'b1; tick();
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== {1'b1, 24'h000022})
            $display("[TB] FAIL mid_after_second: got valid=%b data=%h want valid=1 data=%h", valid_o, data_o, {1'b1, 24'h000022});
        else n_pass++;
        tick(); read_i = 1'b0;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 440; cyc++) begin
            if (cyc < 400) begin
                if (cyc < 150) begin
                    valid_i = 2'($urandom());
                    read_i  = ($urandom_range(0, 3) == 0);
                end else begin
                    valid_i = ($urandom_range(0, 2) == 0) ? 2'($urandom()) : 2'b00;
                    read_i  = ($urandom_range(0, 3) != 0);
                end
                clear_err_i = ($urandom_range(0, 24) == 0);
            end else begin
                valid_i     = '0;
                read_i      = m_valid();
                clear_err_i = 1'b0;
            end
            data_i = {24'($urandom()), 24'($urandom())};
            tick();
            n_checks++; if (valid_o !== m_valid()) $display("[TB] FAIL rand_valid: got %b want %b", valid_o, m_valid()); else n_pass++;
            if (m_valid()) begin
                n_checks++; if (data_o !== mq[0].word) $display("[TB] FAIL rand_data: got %h want %h", data_o, mq[0].word); else n_pass++;
            end
            n_checks++; if (locs_o !== 5'(m_count)) $display("[TB] FAIL rand_locs: got %0d want %0d", locs_o, m_count); else n_pass++;
            n_checks++; if (empty_o !== (m_count == 0)) $display("[TB] FAIL rand_empty: got %b want %b", empty_o, (m_count == 0)); else n_pass++;
            n_checks++; if (full_o !== (m_count == LENGTH)) $display("[TB] FAIL rand_full: got %b want %b", full_o, (m_count == LENGTH)); else n_pass++;
            n_checks++; if (err_overflow_o !== m_ovf) $display("[TB] FAIL rand_ovf: got %b want %b", err_overflow_o, m_ovf); else n_pass++;
            n_checks++; if (err_underflow_o !== m_udf) $display("[TB] FAIL rand_udf: got %b want %b", err_underflow_o, m_udf); else n_pass++;
        end
        read_i = 1'b0; valid_i = '0; clear_err_i = 1'b0;
        n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL rand_final_empty: got %b want 1", empty_o); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; data_i = '0; valid_i = '0; read_i = 1'b0; clear_err_i = 1'b0;
        m_last = CHANNELS - 1; m_count = 0; m_ovf = '0; m_udf = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            m_hold_v[c] = 1'b0;
            m_hold_d[c] = '0;
        end
        test_reset();
        test_streaming();
        test_round_robin();
        test_full_wrap();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
